// File: rtl/gcm_job_sequencer.sv
// gcm_job_sequencer: job-level front end for the gcm_aes core.
// Takes one descriptor, streams AAD then PT blocks from one ingress stream
// into the core with instance framing, returns ciphertext on a backpressured
// egress stream and the tag on a one-shot handshake. The core only advances
// on o_core_ce, so it never sees gaps or has an output overwritten.
module gcm_job_sequencer #(
  parameter int CT_LAT      = 2,
  parameter int CNT_W       = 16,
  parameter int TAG_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  // job descriptor
  input  logic             i_job_valid,
  output logic             o_job_ready,
  input  logic [127:0]     i_job_key,
  input  logic [95:0]      i_job_iv,
  input  logic [CNT_W-1:0] i_job_n_aad,
  input  logic [CNT_W-1:0] i_job_n_pt,
  input  logic [63:0]      i_job_aad_bits,
  input  logic [63:0]      i_job_pt_bits,
  // ingress blocks (AAD first, then PT)
  input  logic             i_blk_valid,
  output logic             o_blk_ready,
  input  logic [127:0]     i_blk_data,
  // ciphertext egress
  output logic             o_ct_valid,
  input  logic             i_ct_ready,
  output logic [127:0]     o_ct_data,
  // tag egress
  output logic             o_tag_valid,
  input  logic             i_tag_ready,
  output logic [127:0]     o_tag,
  output logic             o_err,
  // core side
  output logic             o_core_ce,
  output logic             o_core_new_instance,
  output logic             o_core_pt_instance,
  output logic [127:0]     o_core_key,
  output logic [95:0]      o_core_iv,
  output logic [127:0]     o_core_aad,
  output logic [127:0]     o_core_pt,
  output logic [63:0]      o_core_aad_size,
  output logic [63:0]      o_core_pt_size,
  input  logic [127:0]     i_core_ct,
  input  logic [127:0]     i_core_tag,
  input  logic             i_core_tag_ready
);

  localparam int TMO_W = $clog2(TAG_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_AAD   = 3'd1,
    S_PT    = 3'd2,
    S_ZERO  = 3'd3,
    S_DRAIN = 3'd4,
    S_TAG   = 3'd5
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] n_aad;
  logic [CNT_W-1:0] n_pt;
  logic [CNT_W-1:0] aad_cnt;
  logic [CNT_W-1:0] pt_cnt;
  logic [CT_LAT:1]  pv;        // marks PT blocks travelling through the core
  logic [TMO_W-1:0] tmo_cnt;

  logic in_aad, in_pt, in_zero, in_drain;
  logic stall, fire, pv_empty;

  assign in_aad   = (state == S_AAD);
  assign in_pt    = (state == S_PT);
  assign in_zero  = (state == S_ZERO);
  assign in_drain = (state == S_DRAIN);

  // A presented ciphertext that is not taken freezes the whole core.
  assign o_ct_valid  = pv[CT_LAT];
  assign o_ct_data   = o_ct_valid ? i_core_ct : '0;
  assign stall       = o_ct_valid & ~i_ct_ready;
  assign pv_empty    = ~|pv;

  assign o_job_ready = (state == S_IDLE);
  assign o_blk_ready = (in_aad | in_pt) & ~stall;
  assign fire        = i_blk_valid & o_blk_ready;

  // The empty job gets one forced step so the core still frames an instance.
  assign o_core_ce   = fire | in_zero | (in_drain & ~stall);

  assign o_core_aad  = in_aad ? i_blk_data : '0;
  assign o_core_pt   = in_pt  ? i_blk_data : '0;

  // First block of the job opens the instance, whether it is AAD or PT.
  assign o_core_new_instance =
      (fire & ((in_aad & (aad_cnt == '0)) |
               (in_pt & (pt_cnt == '0) & (n_aad == '0)))) | in_zero;
  assign o_core_pt_instance  = (fire & in_pt & (pt_cnt == '0)) | in_zero;

  // Ciphertext tracker: advances in lockstep with the core's enabled cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pv <= '0;
    end else if (o_core_ce) begin
      pv[1] <= fire & in_pt;
      for (int k = 2; k <= CT_LAT; k++) pv[k] <= pv[k-1];
    end
  end

  // Job FSM: descriptor latch, block counting, drain/tag/timeout handling.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= S_IDLE;
      n_aad           <= '0;
      n_pt            <= '0;
      aad_cnt         <= '0;
      pt_cnt          <= '0;
      tmo_cnt         <= '0;
      o_core_key      <= '0;
      o_core_iv       <= '0;
      o_core_aad_size <= '0;
      o_core_pt_size  <= '0;
      o_tag           <= '0;
      o_tag_valid     <= 1'b0;
      o_err           <= 1'b0;
    end else begin
      o_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_job_valid) begin
            o_core_key      <= i_job_key;
            o_core_iv       <= i_job_iv;
            o_core_aad_size <= i_job_aad_bits;
            o_core_pt_size  <= i_job_pt_bits;
            n_aad           <= i_job_n_aad;
            n_pt            <= i_job_n_pt;
            aad_cnt         <= '0;
            pt_cnt          <= '0;
            tmo_cnt         <= '0;
            if (i_job_n_aad != '0)     state <= S_AAD;
            else if (i_job_n_pt != '0) state <= S_PT;
            else                       state <= S_ZERO;
          end
        end
        S_AAD: begin
          if (fire) begin
            aad_cnt <= aad_cnt + CNT_W'(1);
            if (aad_cnt + CNT_W'(1) == n_aad)
              state <= (n_pt != '0) ? S_PT : S_DRAIN;
          end
        end
        S_PT: begin
          if (fire) begin
            pt_cnt <= pt_cnt + CNT_W'(1);
            if (pt_cnt + CNT_W'(1) == n_pt) state <= S_DRAIN;
          end
        end
        S_ZERO: state <= S_DRAIN;
        S_DRAIN: begin
          // Tag is only trusted once every ciphertext has left the core.
          if (o_core_ce && pv_empty) begin
            if (i_core_tag_ready) begin
              o_tag       <= i_core_tag;
              o_tag_valid <= 1'b1;
              state       <= S_TAG;
            end else if (tmo_cnt == TMO_W'(TAG_TIMEOUT - 1)) begin
              o_err <= 1'b1;
              state <= S_IDLE;
            end else begin
              tmo_cnt <= tmo_cnt + TMO_W'(1);
            end
          end
        end
        S_TAG: begin
          if (i_tag_ready) begin
            o_tag_valid <= 1'b0;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
